// File: rtl/mac_ctrl_pkg.sv
// Shared state encoding and mac_array instruction codes for the tile-job sequencer.
package mac_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        GAP   = 3'd2,
        EXEC  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } ctrlState_t;

    localparam logic [1:0] INST_NOP  = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

endpackage

// File: rtl/mac_ctrl_addr_gen.sv
// Base-plus-offset SRAM address counter; reloaded with a new base at the start of each read phase.
module mac_ctrl_addr_gen
    import mac_ctrl_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clr_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] base_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] off_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            base_q <= '0;
            off_q  <= '0;
        end else if (clr_i) begin
            base_q <= base_i;
            off_q  <= '0;
        end else if (inc_i) begin
            off_q <= off_q + ADDR_W'(1);
        end
    end

    // The sum truncates to ADDR_W, so reads wrap past the top of memory.
    assign addr_o = base_q + off_q;

endmodule

// File: rtl/mac_array_ctrl.sv
// Tile-job sequencer: loads COL weight vectors, waits for the load to ripple, streams activations, drains outputs.
module mac_array_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int ROW      = 8,
    parameter int COL      = 8,
    parameter int ADDR_W   = 11,
    parameter int LEN_W    = 8,
    parameter int DRAIN_TO = 24
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_w_i,
    input  logic [ADDR_W-1:0] base_x_i,
    input  logic [LEN_W-1:0]  num_act_i,
    input  logic [COL-1:0]    valid_i,
    output logic              sram_rd_en_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [1:0]        inst_w_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [LEN_W-1:0]  out_cnt_o
);

    localparam int PHASE_W = (LEN_W > $clog2(COL + ROW)) ? LEN_W : $clog2(COL + ROW);
    localparam int IDLE_W  = $clog2(DRAIN_TO + 1);

    ctrlState_t          state_q;
    logic [PHASE_W-1:0]  cnt_q;
    logic [IDLE_W-1:0]   idle_q;
    logic [IDLE_W-1:0]   idle_d;
    logic [LEN_W-1:0]    outCnt_q;
    logic [LEN_W-1:0]    outCnt_d;
    logic [LEN_W-1:0]    numAct_q;
    logic [ADDR_W-1:0]   baseX_q;
    logic                rdEn_q;
    logic [1:0]          instW_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic                loadLast;
    logic                gapLast;
    logic                execLast;
    logic                countValid;
    logic                drainHit;
    logic                drainTimeout;
    logic                agClr;
    logic                agInc;
    logic [ADDR_W-1:0]   agBase;
    logic                unusedValid;

    // Only column 0 is watched; every column finishes the same vector in the same cycle.
    assign unusedValid = ^valid_i[COL-1:1];

    assign loadLast     = (cnt_q == PHASE_W'(COL - 1));
    assign gapLast      = (cnt_q == PHASE_W'(ROW - 1));
    assign execLast     = (cnt_q == (PHASE_W'(numAct_q) - PHASE_W'(1)));
    assign countValid   = valid_i[0] && ((state_q == EXEC) || (state_q == DRAIN)) && (outCnt_q != '1);
    assign outCnt_d     = outCnt_q + LEN_W'(countValid);
    assign idle_d       = valid_i[0] ? '0 : idle_q + IDLE_W'(1);
    assign drainHit     = (outCnt_d == numAct_q);
    assign drainTimeout = (idle_d == IDLE_W'(DRAIN_TO));

    always_comb begin
        agClr  = 1'b0;
        agInc  = 1'b0;
        agBase = baseX_q;
        case (state_q)
            IDLE: begin
                agClr  = start_i;
                agBase = base_w_i;
            end
            LOAD:    agInc = !loadLast;
            GAP:     agClr = gapLast;
            EXEC:    agInc = !execLast;
            default: ;
        endcase
    end

    mac_ctrl_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (agClr),
        .inc_i   (agInc),
        .base_i  (agBase),
        .addr_o  (sram_addr_o)
    );

    // Read enable is high exactly in LOAD/EXEC, so the instruction one cycle later follows the previous state.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idle_q   <= '0;
            outCnt_q <= '0;
            numAct_q <= '0;
            baseX_q  <= '0;
            rdEn_q   <= 1'b0;
            instW_q  <= INST_NOP;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            outCnt_q <= outCnt_d;
            idle_q   <= (state_q == DRAIN) ? idle_d : '0;
            instW_q  <= (state_q == LOAD) ? INST_LOAD :
                        (state_q == EXEC) ? INST_EXEC : INST_NOP;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        numAct_q <= num_act_i;
                        baseX_q  <= base_x_i;
                        outCnt_q <= '0;
                        err_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        rdEn_q   <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    if (loadLast) begin
                        cnt_q   <= '0;
                        rdEn_q  <= 1'b0;
                        state_q <= GAP;
                    end else begin
                        cnt_q <= cnt_q + PHASE_W'(1);
                    end
                end
                GAP: begin
                    if (gapLast) begin
                        cnt_q <= '0;
                        if (numAct_q == '0) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            rdEn_q  <= 1'b1;
                            state_q <= EXEC;
                        end
                    end else begin
                        cnt_q <= cnt_q + PHASE_W'(1);
                    end
                end
                EXEC: begin
                    if (execLast) begin
                        cnt_q   <= '0;
                        rdEn_q  <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        cnt_q <= cnt_q + PHASE_W'(1);
                    end
                end
                DRAIN: begin
                    // A completing output in the timeout cycle still counts as a clean finish.
                    if (drainHit) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (drainTimeout) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sram_rd_en_o = rdEn_q;
    assign inst_w_o     = instW_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign out_cnt_o    = outCnt_q;

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed bench for mac_array_ctrl: checks read/instruction timing, drain, timeout, wrap and reset per cycle.
module tb_mac_array_ctrl;

    localparam int ROW = 8;
    localparam int COL = 8;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic [10:0] base_w_i;
    logic [10:0] base_x_i;
    logic [7:0]  num_act_i;
    logic [7:0]  valid_i;
    logic        sram_rd_en_o;
    logic [10:0] sram_addr_o;
    logic [1:0]  inst_w_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [7:0]  out_cnt_o;

    int assertCount = 0;
    int failCount   = 0;

    mac_array_ctrl dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .base_w_i     (base_w_i),
        .base_x_i     (base_x_i),
        .num_act_i    (num_act_i),
        .valid_i      (valid_i),
        .sram_rd_en_o (sram_rd_en_o),
        .sram_addr_o  (sram_addr_o),
        .inst_w_o     (inst_w_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .out_cnt_o    (out_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One job whose start is driven in the current cycle (k=0); checks every cycle through done+1.
    task automatic applyStimulus(input string tag, input logic [10:0] bw, input logic [10:0] bx,
                                 input logic [7:0] n, input int vFirst, input int vNum, input int doneK,
                                 input logic expErr, input logic [7:0] expOut, input bit holdStart);
        logic        expRd;
        logic [10:0] expAddr;
        logic [1:0]  expInst;
        start_i   = 1'b1;
        base_w_i  = bw;
        base_x_i  = bx;
        num_act_i = n;
        valid_i   = '0;
        for (int k = 1; k <= doneK + 1; k++) begin
            @(negedge clk_i);
            start_i   = holdStart && (k >= doneK);
            base_w_i  = 11'h555;
            base_x_i  = 11'h2AA;
            num_act_i = 8'hFF;
            valid_i   = (k >= vFirst && k < vFirst + vNum) ? 8'hFF : 8'h00;
            expRd   = (k >= 1 && k <= COL) || (n != 0 && k >= COL + ROW + 1 && k <= COL + ROW + int'(n));
            expAddr = (k <= COL) ? bw + 11'(k - 1) : bx + 11'(k - COL - ROW - 1);
            expInst = (k >= 2 && k <= COL + 1) ? 2'b01 :
                      (n != 0 && k >= COL + ROW + 2 && k <= COL + ROW + 1 + int'(n)) ? 2'b10 : 2'b00;
            checkOutput($sformatf("%s.rd_en@%0d", tag, k), 32'(sram_rd_en_o), 32'(expRd));
            if (expRd)
                checkOutput($sformatf("%s.addr@%0d", tag, k), 32'(sram_addr_o), 32'(expAddr));
            checkOutput($sformatf("%s.inst@%0d", tag, k), 32'(inst_w_o), 32'(expInst));
            checkOutput($sformatf("%s.busy@%0d", tag, k), 32'(busy_o), 32'(k <= doneK));
            checkOutput($sformatf("%s.done@%0d", tag, k), 32'(done_o), 32'(k == doneK));
            checkOutput($sformatf("%s.err@%0d", tag, k), 32'(err_o), 32'((k >= doneK) ? expErr : 1'b0));
            if (k >= doneK)
                checkOutput($sformatf("%s.out_cnt@%0d", tag, k), 32'(out_cnt_o), 32'(expOut));
        end
        valid_i = '0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    initial begin
        reset_i   = 1'b1;
        start_i   = 1'b0;
        base_w_i  = '0;
        base_x_i  = '0;
        num_act_i = '0;
        valid_i   = '0;
        repeat (2) @(negedge clk_i);
        checkOutput("reset.rd_en", 32'(sram_rd_en_o), 32'd0);
        checkOutput("reset.addr", 32'(sram_addr_o), 32'd0);
        checkOutput("reset.inst", 32'(inst_w_o), 32'd0);
        checkOutput("reset.busy", 32'(busy_o), 32'd0);
        checkOutput("reset.done", 32'(done_o), 32'd0);
        checkOutput("reset.err", 32'(err_o), 32'd0);
        checkOutput("reset.out_cnt", 32'(out_cnt_o), 32'd0);
        reset_i = 1'b0;
        @(negedge clk_i);

        $display("[TB] basic job, 4 activations");
        applyStimulus("job1", 11'h010, 11'h100, 8'd4, 19, 4, 23, 1'b0, 8'd4, 1'b0);

        $display("[TB] empty job, valid during GAP ignored");
        applyStimulus("empty", 11'h040, 11'h200, 8'd0, 10, 2, 17, 1'b0, 8'd0, 1'b0);

        $display("[TB] drain timeout");
        applyStimulus("tmo", 11'h080, 11'h300, 8'd3, 18, 2, 44, 1'b1, 8'd2, 1'b0);

        $display("[TB] address wrap, start held through DONE");
        applyStimulus("wrap", 11'h020, 11'h7FE, 8'd4, 18, 4, 22, 1'b0, 8'd4, 1'b1);
        applyStimulus("held", 11'h7FC, 11'h000, 8'd1, 18, 1, 19, 1'b0, 8'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checkOutput($sformatf("held.idle_busy@%0d", i), 32'(busy_o), 32'd0);
        end

        $display("[TB] reset in the middle of EXEC");
        start_i   = 1'b1;
        base_w_i  = 11'h010;
        base_x_i  = 11'h100;
        num_act_i = 8'd4;
        for (int k = 1; k <= COL + ROW + 2; k++) begin
            @(negedge clk_i);
            start_i = 1'b0;
        end
        checkOutput("midrst.pre_rd_en", 32'(sram_rd_en_o), 32'd1);
        checkOutput("midrst.pre_addr", 32'(sram_addr_o), 32'h101);
        #2 reset_i = 1'b1;
        #1;
        checkOutput("midrst.rd_en", 32'(sram_rd_en_o), 32'd0);
        checkOutput("midrst.addr", 32'(sram_addr_o), 32'd0);
        checkOutput("midrst.inst", 32'(inst_w_o), 32'd0);
        checkOutput("midrst.busy", 32'(busy_o), 32'd0);
        checkOutput("midrst.out_cnt", 32'(out_cnt_o), 32'd0);
        @(negedge clk_i);
        reset_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            checkOutput($sformatf("midrst.done@%0d", i), 32'(done_o), 32'd0);
            checkOutput($sformatf("midrst.busy@%0d", i), 32'(busy_o), 32'd0);
        end
        applyStimulus("job6", 11'h010, 11'h100, 8'd4, 19, 4, 23, 1'b0, 8'd4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
